// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction fetch FIFO between program memory and decode.
// Optional same-cycle bypass when empty is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic            flush,
    output logic            req_valid,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_PC,
    input  logic [ILEN-1:0] rsp_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_PC,
    output logic [ILEN-1:0] out_inst,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = CW + 2;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [ILEN-1:0] inst_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [SW-1:0] credit_sum;
    logic [SW-1:0] flush_sum;
    logic          issue;
    logic          rsp_live;
    logic          byp;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // Every issued request already owns a slot, so a response never finds the FIFO full.
    assign credit_sum = SW'(count_q) + SW'(outst_q) + SW'(drop_q);
    assign req_valid  = nReset && !flush && (credit_sum < SW'(DEPTH));
    assign issue      = req_valid && req_ready;

    assign rsp_live = rsp_valid && !flush
                   && (drop_q == '0) && (outst_q != '0);

`ifdef FETCHQ_BYPASS_EN
    assign byp = empty && rsp_live;
`else
    assign byp = 1'b0;
`endif

    assign out_valid = !empty || byp;
    assign wr_en     = rsp_live && !(byp && out_ready);
    assign rd_en     = !empty && out_ready && !flush;

    always_comb begin
        if (byp) begin
            out_PC   = rsp_PC;
            out_inst = rsp_inst;
        end else if (empty) begin
            out_PC   = '0;
            out_inst = '0;
        end else begin
            out_PC   = pc_q[rptr_q];
            out_inst = inst_q[rptr_q];
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        flush_sum = SW'(drop_q) + SW'(outst_q);
        if (flush) begin
            // Everything still in flight belongs to the abandoned path.
            if (rsp_valid && (flush_sum != '0)) begin
                flush_sum = flush_sum - SW'(1);
            end
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            outst_d = '0;
            drop_d  = CW'(flush_sum);
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (rd_en) begin
                rptr_d = rptr_q + PW'(1);
            end
            unique case (1'b1)
                wr_en && !rd_en: count_d = count_q + CW'(1);
                !wr_en && rd_en: count_d = count_q - CW'(1);
                default:         count_d = count_q;
            endcase
            unique case (1'b1)
                issue && !rsp_live: outst_d = outst_q + CW'(1);
                !issue && rsp_live: outst_d = outst_q - CW'(1);
                default:            outst_d = outst_q;
            endcase
            if (rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            pc_q[wptr_q]   <= rsp_PC;
            inst_q[wptr_q] <= rsp_inst;
        end
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (
        @(posedge Clock) disable iff (!nReset)
        !(wr_en && full)
    ) else $error("fetch_queue: push while full");

    a_rsp_protocol: assert property (
        @(posedge Clock) disable iff (!nReset)
        !(rsp_valid && (outst_q == '0) && (drop_q == '0))
    ) else $error("fetch_queue: response without outstanding request");
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed bench for fetch_queue (DEPTH=8).
// Reference model tracks in-flight requests as tagged queue entries.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            Clock = 1'b0;
    logic            nReset = 1'b0;
    logic            flush = 1'b0;
    logic            req_ready = 1'b0;
    logic            rsp_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] rsp_PC = '0;
    logic [ILEN-1:0] rsp_inst = '0;
    logic            req_valid;
    logic            out_valid;
    logic            empty;
    logic            full;
    logic [XLEN-1:0] out_PC;
    logic [ILEN-1:0] out_inst;
    logic [CW-1:0]   count;

    fetch_queue #(
        .XLEN (XLEN),
        .ILEN (ILEN),
        .DEPTH(DEPTH)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .flush    (flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_PC   (rsp_PC),
        .rsp_inst (rsp_inst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_PC   (out_PC),
        .out_inst (out_inst),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] fifo[$];
    logic [31:0] dut_pcs[$];
    logic [31:0] next_pc;
    int          accepted;
    int          errors = 0;
    int          checks = 0;

    logic          s_req, s_ov, s_empty, s_full;
    logic [31:0]   s_pc;
    logic [CW-1:0] s_count;
    logic          cur_rsp, prev_rsp;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9E37) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_clear();
        pend.delete();
        fifo.delete();
        dut_pcs.delete();
        next_pc  = '0;
        accepted = 0;
        cur_rsp  = 1'b0;
        prev_rsp = 1'b0;
    endtask

    task automatic apply_reset();
        nReset    = 1'b0;
        flush     = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        rsp_PC    = '0;
        rsp_inst  = '0;
        model_clear();
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
    endtask

    // One cycle: drive at negedge, sample and score, advance the model.
    task automatic tick(input logic fl, input logic rreq, input logic ren,
                        input logic ordy, input logic [31:0] redir);
        logic        e_req, e_ov, rsp_ok, take;
        logic [31:0] e_pc;
        pend_t       pe;
        flush     = fl;
        req_ready = rreq;
        out_ready = ordy;
        rsp_valid = ren && (pend.size() > 0);
        rsp_PC    = '0;
        rsp_ok    = 1'b0;
        if (rsp_valid) begin
            rsp_PC = pend[0].pc;
            rsp_ok = !fl && !pend[0].stale;
        end
        rsp_inst = inst_of(rsp_PC);
        #1;
        e_req = !fl && (fifo.size() + pend.size() < DEPTH);
        e_ov  = (fifo.size() > 0) || (BYP && rsp_ok);
        e_pc  = (fifo.size() > 0) ? fifo[0] : rsp_PC;
        s_req = req_valid; s_ov = out_valid; s_pc = out_PC;
        s_count = count; s_empty = empty; s_full = full;
        prev_rsp = cur_rsp;
        cur_rsp  = rsp_valid;
        checks++;
        if (req_valid !== e_req) begin
            errors++;
            $display("FAIL req_valid: got %b expected %b t=%0t", req_valid, e_req, $time);
        end
        checks++;
        if (out_valid !== e_ov) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b t=%0t", out_valid, e_ov, $time);
        end
        checks++;
        if (count !== CW'(fifo.size())) begin
            errors++;
            $display("FAIL count: got %0d expected %0d t=%0t", count, fifo.size(), $time);
        end
        checks++;
        if (empty !== (fifo.size() == 0) || full !== (fifo.size() == DEPTH)) begin
            errors++;
            $display("FAIL flags: got empty=%b full=%b expected occupancy %0d t=%0t",
                     empty, full, fifo.size(), $time);
        end
        if (e_ov) begin
            checks++;
            if (out_PC !== e_pc || out_inst !== inst_of(e_pc)) begin
                errors++;
                $display("FAIL head: got pc=%h inst=%h expected pc=%h inst=%h t=%0t",
                         out_PC, out_inst, e_pc, inst_of(e_pc), $time);
            end
        end
        take = e_ov && ordy && !fl;
        if (rsp_valid) begin
            pe = pend.pop_front();
            if (rsp_ok) fifo.push_back(pe.pc);
        end
        if (take) begin
            void'(fifo.pop_front());
            dut_pcs.push_back(out_PC);
        end
        if (fl) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            fifo.delete();
            next_pc = redir;
        end
        if (e_req && rreq) begin
            pend.push_back({next_pc, 1'b0});
            next_pc  = next_pc + 32'd4;
            accepted = accepted + 1;
        end
        @(negedge Clock);
    endtask

    task automatic fill_3q_2o();
        for (int i = 0; i < 100 && !(fifo.size() == 3 && pend.size() == 0); i++) begin
            tick(1'b0, (fifo.size() + pend.size()) < 3, 1'b1, 1'b0, '0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (s_count !== CW'(3) || pend.size() != 2) begin
            errors++;
            $display("FAIL fill: got count=%0d pending=%0d expected 3 and 2", s_count, pend.size());
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        model_clear();
        @(negedge Clock);
        #1;
        checks++;
        if (req_valid !== 1'b0 || out_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_ctl: got req=%b ov=%b cnt=%0d expected 0 0 0",
                     req_valid, out_valid, count);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || out_PC !== '0 || out_inst !== '0) begin
            errors++;
            $display("FAIL reset_out: got empty=%b full=%b pc=%h inst=%h expected 1 0 0 0",
                     empty, full, out_PC, out_inst);
        end
        @(negedge Clock);
        nReset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (s_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req: got %b expected 1", s_req);
        end
    endtask

    task automatic test_stream();
        logic e;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, '0);
            e = BYP ? cur_rsp : prev_rsp;
            checks++;
            if (s_ov !== e || s_count > CW'(1)) begin
                errors++;
                $display("FAIL stream_latency: got ov=%b cnt=%0d expected ov=%b cnt<=1",
                         s_ov, s_count, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_pcs.size() <= i || dut_pcs[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_order: got %h expected %h",
                         (dut_pcs.size() > i) ? dut_pcs[i] : 32'hx, 32'(4 * i));
            end
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 3 * DEPTH; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (accepted != DEPTH || s_full !== 1'b1 || s_count !== CW'(DEPTH) || s_req !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got acc=%0d full=%b cnt=%0d req=%b expected %0d 1 %0d 0",
                     accepted, s_full, s_count, s_req, DEPTH, DEPTH);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b1, '0);
        checks++;
        if (s_ov !== 1'b1 || s_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_first_pop: got ov=%b pc=%h expected 1 0", s_ov, s_pc);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (s_req !== 1'b1) begin
            errors++;
            $display("FAIL full_credit_return: got %b expected 1", s_req);
        end
    endtask

    task automatic test_flush();
        bit seen;
        apply_reset();
        fill_3q_2o();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (s_count !== '0 || s_ov !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got cnt=%0d ov=%b expected 0 0", s_count, s_ov);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, '0);
            if (s_ov === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (s_pc !== 32'h100) begin
                    errors++;
                    $display("FAIL flush_redirect: got %h expected 00000100", s_pc);
                end
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL flush_timeout: got no out_valid expected PC 00000100");
        end
    endtask

    task automatic test_flush_rsp();
        bit seen;
        apply_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h200);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (s_ov !== 1'b0 || s_count !== '0) begin
            errors++;
            $display("FAIL flush_rsp_drop: got ov=%b cnt=%0d expected 0 0", s_ov, s_count);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, '0);
            if (s_ov === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (s_pc !== 32'h200) begin
                    errors++;
                    $display("FAIL flush_rsp_next: got %h expected 00000200", s_pc);
                end
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL flush_rsp_timeout: got no out_valid expected PC 00000200");
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        apply_reset();
        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h300);
        repeat (2) tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h400);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1, '0);
            if (s_ov === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (s_pc !== 32'h400) begin
                    errors++;
                    $display("FAIL b2b_flush: got %h expected 00000400", s_pc);
                end
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL b2b_timeout: got no out_valid expected PC 00000400");
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 600 && dut_pcs.size() < 20; i++) begin
            tick(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 1'($urandom_range(0, 1)), '0);
        end
        checks++;
        if (dut_pcs.size() < 20) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d pops expected 20", dut_pcs.size());
        end
        for (int i = 0; i < 20 && i < dut_pcs.size(); i++) begin
            checks++;
            if (dut_pcs[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %h expected %h", i, dut_pcs[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fill_3q_2o();
        #2;
        nReset    = 1'b0;
        req_ready = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || out_valid !== 1'b0 || count !== '0 || empty !== 1'b1
            || full !== 1'b0 || out_PC !== '0 || out_inst !== '0) begin
            errors++;
            $display("FAIL reset_mid: got req=%b ov=%b cnt=%0d empty=%b full=%b pc=%h",
                     req_valid, out_valid, count, empty, full, out_PC);
        end
        apply_reset();
        repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b1, '0);
        checks++;
        if (dut_pcs.size() == 0 || dut_pcs[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_resume: got %0d pops expected first PC 0", dut_pcs.size());
        end
    endtask

    task automatic test_bypass();
        logic e_ov0;
        logic [CW-1:0] e_cnt0;
        apply_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, '0);
        e_ov0  = BYP;
        e_cnt0 = BYP ? CW'(0) : CW'(1);
        checks++;
        if (s_ov !== e_ov0) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %b expected %b", s_ov, e_ov0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (s_count !== e_cnt0 || s_ov !== !BYP) begin
            errors++;
            $display("FAIL bypass_next: got cnt=%0d ov=%b expected %0d %b",
                     s_count, s_ov, e_cnt0, !BYP);
        end
        checks++;
        if (dut_pcs.size() != 1 || dut_pcs[0] !== 32'h0) begin
            errors++;
            $display("FAIL bypass_pc: got %0d pops expected one PC 0", dut_pcs.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_flush_rsp();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction fetch queue between program memory and the decode stage.
- Issues credit-limited fetch requests and buffers {PC, instruction} responses in a DEPTH-entry FIFO.
- Presents buffered entries to decode with a valid/ready handshake.
- Replaces the single-entry IF register: adds multi-entry buffering, outstanding-request tracking and flush-safe discard of in-flight responses.

Parameters:
- XLEN, 32, PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH+1), width of occupancy and outstanding counters (derived, not overridden).

Ports:
- Clock  input  1  rising-edge clock
- nReset  input  1  asynchronous active-low reset
- flush  input  1  discard all queued entries and all in-flight responses
- req_valid  output  1  fetch request may be issued this cycle
- req_ready  input  1  program memory accepts request
- rsp_valid  input  1  program memory returns a response
- rsp_PC  input  XLEN  PC of the returned instruction
- rsp_inst  input  ILEN  returned instruction
- out_valid  output  1  head entry valid to decode
- out_ready  input  1  decode consumes head (not hold)
- out_PC  output  XLEN  head PC
- out_inst  output  ILEN  head instruction
- count  output  CW  current FIFO occupancy
- empty  output  1  count == 0
- full  output  1  count == DEPTH

Behaviour:
- One clock, Clock. Reset is asynchronous and active-low on nReset.
- Reset values: count=0, outstanding=0, drop_cnt=0, read and write pointers=0, out_valid=0, empty=1, full=0.
  - out_PC/out_inst are 0 while empty after reset.
  - req_valid=0 while nReset low; it rises in the first cycle after release.
- Reset asserted mid-operation clears all state immediately. Pending responses after reset are treated as protocol errors (see below).
- Credit rule: req_valid = !flush && (count + outstanding + drop_cnt < DEPTH). This guarantees a response always has a free slot.
- outstanding (CW bits):
  - +1 on req_valid&&req_ready.
  - -1 on an accepted, non-dropped rsp_valid.
  - Simultaneous inc and dec leaves it unchanged.
- Push: rsp_valid && drop_cnt==0 && !flush && outstanding>0 writes {rsp_PC, rsp_inst} at the write pointer. The write pointer wraps modulo DEPTH.
- Pop: out_valid && out_ready && !flush advances the read pointer (mod DEPTH).
  - Simultaneous push and pop leaves count unchanged.
  - Push while full cannot occur under the credit rule; a simulation assertion fires if it does.
- out_valid = !empty. Outputs are driven from the head register (registered output, no combinational path from rsp_* by default).
- Minimum latency is 1 cycle: a response accepted in cycle N is visible as out_valid in cycle N+1.
- Flush (single cycle, highest priority):
  - Next state: count=0, pointers=0.
  - drop_cnt <= drop_cnt + outstanding − (rsp_valid this cycle ? 1 : 0), saturating at 0. Equivalently, every request issued before the flush is marked for discard.
  - outstanding <= 0.
  - A rsp_valid coincident with flush is discarded.
  - A pop coincident with flush does not occur (out_valid may be 1, but the consumer must ignore it; decode is flushed too).
- Drop phase: while drop_cnt>0, each rsp_valid decrements drop_cnt and is not written. Requests may still issue if the credit rule allows.
- Back-to-back flushes accumulate correctly in drop_cnt.
- Protocol error: rsp_valid with outstanding==0 and drop_cnt==0 is ignored (no state change) and raises a simulation assertion.
- Arithmetic: all counters are CW bits. Pointers are $clog2(DEPTH) bits with natural wrap.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined: when empty and a push-eligible rsp_valid arrives, out_valid/out_PC/out_inst are driven combinationally from rsp_* in the same cycle.
  - If out_ready is also 1, the entry is consumed and not written; count stays 0.
  - Zero-cycle latency when empty.
- Undefined: no bypass; 1-cycle minimum latency as above, and outputs are purely registered.

Test Plan:
- Reset release with req_ready=1, rsp_valid 1 cycle after each request, out_ready=1 -> req_valid=1 from the first post-reset cycle; PCs 0x0,0x4,0x8 appear on out_PC in order; count never exceeds 1; without bypass, out_valid lags rsp_valid by exactly 1 cycle.
- out_ready=0 with continuous fetch, DEPTH=4 -> exactly 4 requests accepted; full=1, count=4, req_valid=0; first out_ready=1 pops 0x0 and req_valid returns next cycle.
- 2 outstanding requests, then flush with 3 entries queued -> count=0 next cycle; the next 2 rsp_valid are not written (out_valid stays 0); the third response (PC 0x100 after redirect) appears on out_PC.
- flush coincident with rsp_valid and 1 outstanding -> response discarded; drop_cnt=0 afterwards; the next response is accepted.
- Pointer wrap at DEPTH=8: push/pop 20 sequential PCs with random out_ready -> output order preserved across wrap; count matches the reference model every cycle.
- nReset pulled low with 3 entries and 2 outstanding -> all outputs return to reset values asynchronously; FETCHQ_BYPASS_EN build: empty queue plus rsp_valid and out_ready -> out_valid=1 in the same cycle and count stays 0.
